// File: rtl/cmd_interp_out_queue.sv
// Multi-channel result collector: N_CH producer channels feed a DEPTH-entry FIFO
// drained through a valid/ready output, with sticky overflow/collision flags.
module cmd_interp_out_queue #(
  parameter int W     = 8,
  parameter int N_CH  = 2,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH*W-1:0]         in,
  input  logic [N_CH-1:0]           load,
  output logic [W-1:0]              out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      overflow,
  output logic                      collision,
  input  logic                      clr_flags
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [W-1:0]  last_q;

  logic          push;
  logic          pop;
  logic          push_acc;
  logic          overflow_evt;
  logic          collision_evt;
  logic [W-1:0]  push_data;

  // Scan from the top down so the lowest-index channel with load set wins.
  always_comb begin
    push_data = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (load[i]) push_data = in[i*W +: W];
    end
  end

  always_comb begin
    push          = |load;
    pop           = out_valid & out_ready;
    push_acc      = push & (!full | pop);
    overflow_evt  = push & full & !pop;
    collision_evt = ($countones(load) > 1);
  end

  assign out_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign out       = out_valid ? mem[rd_ptr] : last_q;

  // Storage carries no reset; only entries covered by count are ever shown.
  always_ff @(posedge clk) begin
    if (!rst && push_acc) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_q    <= '0;
      overflow  <= 1'b0;
      collision <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        last_q <= mem[rd_ptr];
      end
      case ({push_acc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A new event in the same cycle as a clear keeps the flag set.
      overflow  <= overflow_evt  | (overflow  & !clr_flags);
      collision <= collision_evt | (collision & !clr_flags);
    end
  end

endmodule
